// File: rtl/if_id_elastic.sv
// IF/ID pipeline register with a one-entry skid buffer: full throughput, registered
// in_ready/out_valid, synchronous flush and a saturating back-pressure counter.
module if_id_elastic #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic               main_valid_q, main_valid_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc_q,    main_pc_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
  logic [CNT_W-1:0]   stall_q,      stall_d;

  logic in_hs;
  logic main_free;

  assign in_ready  = ~skid_valid_q;
  assign in_hs     = in_valid & in_ready;
  assign main_free = ~main_valid_q | out_ready;

  // Main refills from skid first so beats leave in acceptance order.
  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_instr_d = skid_instr_q;
        main_pc_d    = skid_pc_q;
        skid_valid_d = in_hs;
        if (in_hs) begin
          skid_instr_d = instr_in;
          skid_pc_d    = pc_in;
        end
      end else if (in_hs) begin
        main_valid_d = 1'b1;
        main_instr_d = instr_in;
        main_pc_d    = pc_in;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_hs) begin
      skid_valid_d = 1'b1;
      skid_instr_d = instr_in;
      skid_pc_d    = pc_in;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!flush && main_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      stall_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      stall_q      <= stall_d;
    end
  end

  assign out_valid = main_valid_q;
  assign instr_out = main_valid_q ? main_instr_q : NOP_INSTR;
  assign pc_out    = main_pc_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign stall_cnt = stall_q;

endmodule
